// File: rtl/serial_operand_feeder_pkg.sv
// Shared definitions for the serial adder feeder: controller state encodings and default widths.
// The same defaults are used by the serial adder so both ends agree on the stream length.
package serial_operand_feeder_pkg;

  localparam int N_DEF       = 4;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SHIFT = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/serial_operand_feeder_if.sv
// Bundle of the feeder's upstream, adder-side and downstream handshake signals.
// master is the feeder's view; slave is the view of the surrounding environment.
interface serial_operand_feeder_if
  import serial_operand_feeder_pkg::*;
#(
  parameter int N = N_DEF
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         start;
  logic         si;
  logic         done;
  logic [N-1:0] result;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum_out;
  logic         timeout_err;
  logic         busy;

  modport master (
    input  in_valid, a_in, b_in, done, result, out_ready,
    output in_ready, start, si, out_valid, sum_out, timeout_err, busy
  );

  modport slave (
    output in_valid, a_in, b_in, done, result, out_ready,
    input  in_ready, start, si, out_valid, sum_out, timeout_err, busy
  );
endinterface

// File: rtl/serial_operand_feeder_piso_shift_reg.sv
// Parallel-in serial-out register: loads {B,A} and exposes the LSB, shifting right one bit per enable.
// Load has priority over shift.
module piso_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_din,
  output logic         o_lsb
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_shift) begin
      r_q <= {1'b0, r_q[W-1:1]};
    end
  end

  assign o_lsb = r_q[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Upstream controller for the serial adder: accepts an operand pair, streams A then B LSB-first,
// waits (with a watchdog) for done, and holds the captured sum until downstream accepts it.
module serial_operand_feeder
  import serial_operand_feeder_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  serial_operand_feeder_if.master bus
);

  localparam int BW = $clog2(2 * N);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [BW-1:0] LAST_BIT = BW'(2 * N - 1);
  localparam logic [TW-1:0] LAST_TMO = TW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BW-1:0] r_bitcnt;
  logic [TW-1:0] r_tmo;
  logic          r_start;
  logic          r_si;
  logic          r_out_valid;
  logic [N-1:0]  r_sum;
  logic          r_timeout_err;
  logic          r_in_ready;
  logic          r_busy;
  logic          w_load;
  logic          w_shift;
  logic          w_lsb;
  logic          w_expire;

  piso_shift_reg #(.W(2 * N)) u_piso (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_din   ({bus.b_in, bus.a_in}),
    .o_lsb   (w_lsb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The START cycle already pops bit 0 so si shows it on the first SHIFT (adder LOAD) cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_shift     = 1'b1;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (r_bitcnt == LAST_BIT) begin
          w_state_nxt = WAIT;
        end else begin
          w_shift = 1'b1;
        end
      end
      WAIT: begin
        if (bus.done) begin
          w_state_nxt = HOLD;
        end else if (r_tmo == LAST_TMO) begin
          w_expire    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bitcnt      <= '0;
      r_tmo         <= '0;
      r_start       <= 1'b0;
      r_si          <= 1'b0;
      r_out_valid   <= 1'b0;
      r_sum         <= '0;
      r_timeout_err <= 1'b0;
      r_in_ready    <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      r_bitcnt   <= (r_state == SHIFT) ? r_bitcnt + BW'(1) : '0;
      r_tmo      <= (r_state == WAIT) ? r_tmo + TW'(1) : '0;
      r_start    <= (w_state_nxt == START);
      r_si       <= w_shift ? w_lsb : 1'b0;
      r_in_ready <= (w_state_nxt == IDLE);
      r_busy     <= (w_state_nxt != IDLE);

      if (r_state == WAIT && bus.done) begin
        r_sum       <= bus.result;
        r_out_valid <= 1'b1;
      end else if (r_state == HOLD && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_load) begin
        r_timeout_err <= 1'b0;
      end else if (w_expire) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.start       = r_start;
  assign bus.si          = r_si;
  assign bus.out_valid   = r_out_valid;
  assign bus.sum_out     = r_sum;
  assign bus.timeout_err = r_timeout_err;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench: feeder driving a behavioural 4-bit serial adder (switchable to a done-less stub).
module tb_serial_operand_feeder;

  logic clk;
  logic rst_n;
  bit   stub_mode;
  int   checks;
  int   failures;
  logic [7:0] si_vec;
  logic       si_tail;

  serial_operand_feeder_if #(.N(4)) bus ();

  serial_operand_feeder #(.N(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial adder model: start, 8 LOAD cycles sampling si, then done a fixed delay later.
  typedef enum logic [1:0] {A_IDLE, A_LOAD, A_ADD} add_st_t;
  add_st_t    r_ast;
  logic [7:0] r_asr;
  logic [2:0] r_acnt;
  logic       r_adone;
  logic [3:0] r_ares;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ast   <= A_IDLE;
      r_asr   <= '0;
      r_acnt  <= '0;
      r_adone <= 1'b0;
      r_ares  <= '0;
    end else begin
      r_adone <= 1'b0;
      case (r_ast)
        A_IDLE: if (bus.start) begin
          r_ast  <= A_LOAD;
          r_acnt <= '0;
        end
        A_LOAD: begin
          r_asr  <= {bus.si, r_asr[7:1]};
          r_acnt <= r_acnt + 3'd1;
          if (r_acnt == 3'd7) begin
            r_ast  <= A_ADD;
            r_acnt <= '0;
          end
        end
        A_ADD: begin
          if (r_acnt == 3'd5) begin
            r_adone <= 1'b1;
            r_ares  <= r_asr[3:0] + r_asr[7:4];
            r_ast   <= A_IDLE;
          end else begin
            r_acnt <= r_acnt + 3'd1;
          end
        end
        default: r_ast <= A_IDLE;
      endcase
    end
  end

  assign bus.done   = r_adone & ~stub_mode;
  assign bus.result = r_ares;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accepts one pair from IDLE and returns once out_valid rises (or the bound expires).
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp, input bit keep_valid);
    int lat;
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 40) begin
      tick();
      guard++;
    end
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    bus.a_in = a;
    bus.b_in = b;
    bus.in_valid = 1'b1;
    tick();
    if (!keep_valid) bus.in_valid = 1'b0;
    chk({tag, "_start"}, bus.start, 1);
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_err_clr"}, bus.timeout_err, 0);
    lat = 0;
    si_vec = '0;
    si_tail = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
      if (lat >= 1 && lat <= 8) si_vec[lat-1] = bus.si;
      if (lat == 9) si_tail = bus.si;
    end
    chk({tag, "_latency"}, lat, 16);
    chk({tag, "_sum"}, bus.sum_out, exp);
  endtask

  task automatic ack(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_ack_ov"}, bus.out_valid, 0);
    chk({tag, "_ack_rdy"}, bus.in_ready, 1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    stub_mode = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();

    chk("rst_start", bus.start, 0);
    chk("rst_si", bus.si, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum_out, 0);
    chk("rst_err", bus.timeout_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: A=3,B=5
    run_op("t1", 4'd3, 4'd5, 4'd8, 1'b0);
    chk("t1_si_stream", si_vec, 8'b0101_0011);
    chk("t1_si_idle", si_tail, 0);
    ack("t1");

    // 2: wrap and corner values
    run_op("t2a", 4'd15, 4'd1, 4'd0, 1'b0);
    ack("t2a");
    run_op("t2b", 4'd0, 4'd0, 4'd0, 1'b0);
    ack("t2b");
    run_op("t2c", 4'd7, 4'd7, 4'd14, 1'b0);
    ack("t2c");

    // 3: downstream stall with upstream pressure
    run_op("t3", 4'd9, 4'd4, 4'd13, 1'b0);
    bus.in_valid = 1'b1;
    bus.a_in = 4'd1;
    bus.b_in = 4'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_ov", bus.out_valid, 1);
      chk("t3_hold_sum", bus.sum_out, 13);
      chk("t3_hold_rdy", bus.in_ready, 0);
      chk("t3_hold_start", bus.start, 0);
    end
    bus.in_valid = 1'b0;
    ack("t3");
    chk("t3_idle_busy", bus.busy, 0);

    // 4: watchdog with a done-less adder
    stub_mode = 1'b1;
    bus.a_in = 4'd6;
    bus.b_in = 4'd6;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (24) tick();
    chk("t4_err_early", bus.timeout_err, 0);
    chk("t4_busy_wait", bus.busy, 1);
    tick();
    chk("t4_err_set", bus.timeout_err, 1);
    chk("t4_idle_rdy", bus.in_ready, 1);
    chk("t4_idle_busy", bus.busy, 0);
    chk("t4_no_ov", bus.out_valid, 0);
    tick();
    chk("t4_err_sticky", bus.timeout_err, 1);
    stub_mode = 1'b0;
    run_op("t4n", 4'd5, 4'd6, 4'd11, 1'b0);
    ack("t4n");

    // 5: reset during SHIFT bit 5
    bus.a_in = 4'd15;
    bus.b_in = 4'd15;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    chk("t5_pre_si", bus.si, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_start", bus.start, 0);
    chk("t5_rst_si", bus.si, 0);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_rdy", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("t5", 4'd2, 4'd9, 4'd11, 1'b0);
    ack("t5");

    // 6: back-to-back with in_valid and out_ready held high
    bus.out_ready = 1'b1;
    run_op("t6a", 4'd1, 4'd2, 4'd3, 1'b1);
    tick();
    chk("t6a_gap_rdy", bus.in_ready, 1);
    chk("t6a_gap_ov", bus.out_valid, 0);
    run_op("t6b", 4'd8, 4'd8, 4'd0, 1'b1);
    tick();
    chk("t6b_gap_rdy", bus.in_ready, 1);
    run_op("t6c", 4'd12, 4'd2, 4'd14, 1'b1);
    tick();
    chk("t6c_gap_rdy", bus.in_ready, 1);
    run_op("t6d", 4'd6, 4'd5, 4'd11, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    chk("t6d_gap_rdy", bus.in_ready, 1);
    chk("t6d_gap_ov", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
